// File: rtl/vmem_term_ctrl.sv
// Text-mode terminal controller: turns keyboard codes into character-memory
// writes, tracks the cursor and sweeps rows / the whole screen with BLANK.
module vmem_term_ctrl #(
  parameter int unsigned COLS  = 70,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  key_in,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic        clr_req,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic        busy
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  localparam logic [7:0] KEY_BS = 8'h08;
  localparam logic [7:0] KEY_LF = 8'h0A;
  localparam logic [7:0] KEY_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLR_ROW = 2'd1,
    ST_CLR_ALL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  col_q, col_d;        // sweep column counter
  logic [4:0]  row_q, row_d;        // sweep row counter (full-screen sweep only)
  logic [6:0]  cur_x_q, cur_x_d;
  logic [4:0]  cur_y_q, cur_y_d;
  logic        clr_pend_q, clr_pend_d;
  logic        mem_we_q, mem_we_d;
  logic [11:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;

  // Row after r, wrapping from the last row back to the top.
  function automatic logic [4:0] next_row(input logic [4:0] r);
    if (r == LAST_ROW) begin
      return 5'd0;
    end else begin
      return r + 5'd1;
    end
  endfunction

  // State register: reset restarts the full-screen sweep from cell (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLR_ALL;
      col_q       <= 7'd0;
      row_q       <= 5'd0;
      cur_x_q     <= 7'd0;
      cur_y_q     <= 5'd0;
      clr_pend_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 12'd0;
      mem_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      clr_pend_q  <= clr_pend_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic: key handling in IDLE and the two BLANK sweeps.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    clr_pend_d  = clr_pend_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (clr_req || clr_pend_q) begin
          // A screen clear beats any key offered in the same cycle.
          state_d    = ST_CLR_ALL;
          clr_pend_d = 1'b0;
          col_d      = 7'd0;
          row_d      = 5'd0;
        end else if (key_valid) begin
          case (key_in)
            KEY_LF: begin
              cur_x_d = 7'd0;
              cur_y_d = next_row(cur_y_q);
              col_d   = 7'd0;
              state_d = ST_CLR_ROW;
            end
            KEY_CR: begin
              cur_x_d = 7'd0;
            end
            KEY_BS: begin
              if (cur_x_q != 7'd0) begin
                cur_x_d     = cur_x_q - 7'd1;
                mem_we_d    = 1'b1;
                mem_addr_d  = {cur_x_d, cur_y_q};
                mem_wdata_d = BLANK;
              end else if (cur_y_q != 5'd0) begin
                cur_x_d     = LAST_COL;
                cur_y_d     = cur_y_q - 5'd1;
                mem_we_d    = 1'b1;
                mem_addr_d  = {cur_x_d, cur_y_d};
                mem_wdata_d = BLANK;
              end else begin
                // Top-left corner: nothing to erase.
                cur_x_d = cur_x_q;
              end
            end
            default: begin
              // Printable character: store it, then advance (wrapping to a newline).
              mem_we_d    = 1'b1;
              mem_addr_d  = {cur_x_q, cur_y_q};
              mem_wdata_d = key_in;
              if (cur_x_q == LAST_COL) begin
                cur_x_d = 7'd0;
                cur_y_d = next_row(cur_y_q);
                col_d   = 7'd0;
                state_d = ST_CLR_ROW;
              end else begin
                cur_x_d = cur_x_q + 7'd1;
              end
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CLR_ROW: begin
        clr_pend_d  = clr_pend_q | clr_req;
        mem_we_d    = 1'b1;
        mem_addr_d  = {col_q, cur_y_q};
        mem_wdata_d = BLANK;
        if (col_q == LAST_COL) begin
          col_d   = 7'd0;
          state_d = ST_IDLE;
        end else begin
          col_d = col_q + 7'd1;
        end
      end

      ST_CLR_ALL: begin
        clr_pend_d  = clr_pend_q | clr_req;
        mem_we_d    = 1'b1;
        mem_addr_d  = {col_q, row_q};
        mem_wdata_d = BLANK;
        if (col_q == LAST_COL) begin
          col_d = 7'd0;
          if (row_q == LAST_ROW) begin
            row_d   = 5'd0;
            cur_x_d = 7'd0;
            cur_y_d = 5'd0;
            state_d = ST_IDLE;
          end else begin
            row_d = row_q + 5'd1;
          end
        end else begin
          col_d = col_q + 7'd1;
        end
      end

      default: begin
        state_d = ST_CLR_ALL;
        col_d   = 7'd0;
        row_d   = 5'd0;
      end
    endcase
  end

  // Output logic: handshake and status derived from the state register.
  always_comb begin
    busy      = reset | (state_q != ST_IDLE);
    key_ready = !reset && (state_q == ST_IDLE) && !clr_req && !clr_pend_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    cur_x     = cur_x_q;
    cur_y     = cur_y_q;
  end

endmodule

// File: doc/vmem_term_ctrl.md
VMEM_TERM_CTRL -- requirements
Module: vmem_term_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 70, characters per text row.
REQ-002 SHALL have parameter ROWS, default 30, text rows per screen.
REQ-003 SHALL have parameter BLANK, default 8'h00, code written when a cell is cleared.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 key_in  input  8  ASCII code from the keyboard decoder.
REQ-007 key_valid  input  1  key_in valid.
REQ-008 key_ready  output  1  controller can accept a key this cycle.
REQ-009 clr_req  input  1  one-cycle request to clear the whole screen.
REQ-010 mem_we  output  1  character-memory write enable.
REQ-011 mem_addr  output  12  write address {col[6:0], row[4:0]}.
REQ-012 mem_wdata  output  8  write data.
REQ-013 cur_x  output  7  cursor column; cur_y  output  5  cursor row.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, CLR_ROW and CLR_ALL.
REQ-016 SHALL drive key_ready = (state==IDLE) && !clr_req && !clr_pend; a key is accepted when key_valid && key_ready.
REQ-017 SHALL register mem_we/mem_addr/mem_wdata, so a write decided in cycle t is presented in cycle t+1; mem_we is 0 in every other cycle.
REQ-018 Printable key (any code except 8'h08, 8'h0A, 8'h0D): SHALL write key_in at {cur_x,cur_y}, then advance cur_x by 1.
REQ-019 Advance from cur_x==COLS-1: SHALL set cur_x=0 and perform a newline.
REQ-020 Newline (8'h0A, or wrap per REQ-019): SHALL set cur_x=0 and cur_y = (cur_y==ROWS-1) ? 0 : cur_y+1, then enter CLR_ROW for the new cur_y.
REQ-021 8'h0D: SHALL set cur_x=0 with no write and no row change.
REQ-022 8'h08 backspace: if cur_x>0, cur_x-1; if cur_x==0 && cur_y>0, cur_x=COLS-1 and cur_y-1; then SHALL write BLANK at the new cursor; at (0,0) SHALL do nothing (no write).
REQ-023 CLR_ROW SHALL issue exactly COLS writes of BLANK on consecutive cycles, col 0..COLS-1, row cur_y, then return to IDLE.
REQ-024 CLR_ALL SHALL issue exactly COLS*ROWS writes of BLANK on consecutive cycles, row-major (row 0..ROWS-1 outer, col 0..COLS-1 inner), then set cursor to (0,0) and return to IDLE.
REQ-025 clr_req in IDLE SHALL enter CLR_ALL next cycle; it wins over a simultaneous key_valid, and that key is not accepted.
REQ-026 clr_req outside IDLE SHALL set sticky clr_pend; on return to IDLE the controller SHALL enter CLR_ALL next cycle and clear clr_pend; multiple requests collapse into one.
REQ-027 cur_x/cur_y SHALL never exceed COLS-1/ROWS-1; column and row arithmetic wraps only as stated above.

Reset
REQ-028 While reset is high: mem_we=0, mem_addr=0, mem_wdata=0, cur_x=0, cur_y=0, clr_pend=0, key_ready=0, busy=1; state forced to CLR_ALL with sweep counters 0.
REQ-029 The first cycle after reset deassertion SHALL start the CLR_ALL sweep; reset asserted mid-sweep or mid-row SHALL abort it and restart per REQ-028.

Verification
REQ-030 Release reset -> busy=1 for 2100 cycles, 2100 writes of 8'h00, first {0,0}, last {69,29}; then key_ready=1, cursor (0,0).
REQ-031 Key 8'h41 at (0,0) -> next cycle mem_we=1, addr {0,0}, data 8'h41; cur_x=1.
REQ-032 70 printable keys from (0,0) -> last write at {69,0}; cursor (0,1); 70 BLANK writes to row 1; key_ready=0 during those 70 cycles.
REQ-033 Backspace at (0,1) -> cursor (69,0), write 8'h00 at {69,0}; backspace at (0,0) -> no write, cursor unchanged.
REQ-034 8'h0A at row 29 -> cursor (0,0), row 0 cleared (70 writes); 8'h0D at (5,3) -> cursor (0,3), no write.
REQ-035 clr_req and key_valid in the same IDLE cycle -> key not accepted, full 2100-write sweep; clr_req during CLR_ROW -> row sweep completes, then full sweep starts one cycle later.
